// File: rtl/calc_drv_if.sv
// calc_drv_if: handshake bundle for the calc_drv sequencer.
//
//   Input side  : in_valid, in_ready, in_x, in_w   (one vector pair per transfer)
//   Output side : out_valid, out_ready, res_act, res_sum (res_sum only when
//                 CALC_DRV_SUM_EN is defined)
//
//   modport slave  - the sequencer (consumes vectors, produces results)
//   modport master - the producer/consumer driving the sequencer
interface calc_drv_if #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 12
);
    logic                     in_valid;
    logic                     in_ready;
    logic [VEC_LEN-1:0]       in_x;
    logic [VEC_LEN-1:0]       in_w;
    logic                     out_valid;
    logic                     out_ready;
    logic                     res_act;
`ifdef CALC_DRV_SUM_EN
    logic signed [ACC_W-1:0]  res_sum;
`endif

    modport slave (
        input  in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, res_act
`ifdef CALC_DRV_SUM_EN
        , output res_sum
`endif
    );

    modport master (
        output in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, res_act
`ifdef CALC_DRV_SUM_EN
        , input res_sum
`endif
    );
endinterface

// File: rtl/calc_drv.sv
// calc_drv: sequencer for the calc neuron datapath.
//
// Accepts an activation/weight vector pair, streams it LSB-first one bit pair
// per cycle onto calc_1/calc_in, keeps the accumulator cleared whenever no
// stream is in flight, and captures the activated result (and optionally the
// raw sum) one cycle after the last bit. The result is held until consumed.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   bus       calc_drv_if.slave (in_valid/in_ready/in_x/in_w,
//             out_valid/out_ready/res_act[/res_sum])
//   calc_1    activation bit to the ALU
//   calc_in   op bit to the ALU
//   calc_clr  accumulator clear request (active high)
//   agg_act   activated result from the calc block
//   agg_sum   accumulator value from the calc block
//   busy      high while streaming or sampling
//
// Build option: define CALC_DRV_SUM_EN to capture agg_sum into res_sum.
module calc_drv #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    calc_drv_if.slave               bus,
    output logic                    calc_1,
    output logic                    calc_in,
    output logic                    calc_clr,
    input  logic                    agg_act,
    input  logic signed [ACC_W-1:0] agg_sum,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   idx;
    logic [VEC_LEN-1:0] x_sr;
    logic [VEC_LEN-1:0] w_sr;
    logic               res_act_q;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore outputs. calc_clr is low only while bits are
    // flowing and during the sample cycle, so the accumulator starts every
    // stream at zero and still holds the final sum when it is captured.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        calc_clr      = 1'b1;
        calc_1        = 1'b0;
        calc_in       = 1'b0;
        busy          = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = STREAM;
            end
            STREAM: begin
                calc_clr = 1'b0;
                calc_1   = x_sr[0];
                calc_in  = w_sr[0];
                busy     = 1'b1;
                if (idx == LAST_IDX) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                calc_clr  = 1'b0;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift registers and bit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            x_sr <= '0;
            w_sr <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            idx  <= '0;
            x_sr <= bus.in_x;
            w_sr <= bus.in_w;
        end else if (state == STREAM) begin
            idx  <= idx + 1'b1;
            x_sr <= x_sr >> 1;
            w_sr <= w_sr >> 1;
        end
    end

    // Result capture at the end of the sample cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_act_q <= 1'b0;
        end else if (state == SAMPLE) begin
            res_act_q <= agg_act;
        end
    end

    assign bus.res_act = res_act_q;

`ifdef CALC_DRV_SUM_EN
    logic signed [ACC_W-1:0] res_sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_sum_q <= '0;
        end else if (state == SAMPLE) begin
            res_sum_q <= agg_sum;
        end
    end

    assign bus.res_sum = res_sum_q;
`else
    // Sum capture is not built; the accumulator value is intentionally ignored.
    logic unused_agg_sum;
    assign unused_agg_sum = ^agg_sum;
`endif

endmodule

// File: tb/tb_calc_drv.sv
// tb_calc_drv: directed bench for calc_drv (VEC_LEN=16 and VEC_LEN=1 instances).
module tb_calc_drv;
    localparam int ACC_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    calc_drv_if #(.VEC_LEN(16), .ACC_W(ACC_W)) bus16();
    calc_drv_if #(.VEC_LEN(1),  .ACC_W(ACC_W)) bus1();

    logic                    c1_16, cin_16, clr_16, act_16, busy_16;
    logic signed [ACC_W-1:0] sum_16;
    logic                    c1_1, cin_1, clr_1, act_1, busy_1;
    logic signed [ACC_W-1:0] sum_1;

    calc_drv #(.VEC_LEN(16), .ACC_W(ACC_W), .CNT_W(5)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16.slave),
        .calc_1(c1_16), .calc_in(cin_16), .calc_clr(clr_16),
        .agg_act(act_16), .agg_sum(sum_16), .busy(busy_16)
    );

    calc_drv #(.VEC_LEN(1), .ACC_W(ACC_W), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .calc_1(c1_1), .calc_in(cin_1), .calc_clr(clr_1),
        .agg_act(act_1), .agg_sum(sum_1), .busy(busy_1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A5C3 / 0F0F, LSB first
    bit exp_c1  [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    bit exp_cin [16] = '{1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        bus16.in_valid = 0; bus16.in_x = '0; bus16.in_w = '0; bus16.out_ready = 0;
        bus1.in_valid  = 0; bus1.in_x  = '0; bus1.in_w  = '0; bus1.out_ready  = 0;
        act_16 = 0; sum_16 = '0; act_1 = 0; sum_1 = '0;

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        check("por_in_ready", bus16.in_ready, 1);
        check("por_calc_clr", clr_16, 1);
        check("por_calc_1", c1_16, 0);
        check("por_out_valid", bus16.out_valid, 0);
        check("por_busy", busy_16, 0);
        check("por_res_act", bus16.res_act, 0);
`ifdef CALC_DRV_SUM_EN
        check("por_res_sum", $unsigned(bus16.res_sum), 0);
`endif
        @(negedge clk) rst = 1;
        tick();

        // T1: bit order and capture
        bus16.in_x = 16'hA5C3; bus16.in_w = 16'h0F0F; bus16.in_valid = 1;
        tick();
        bus16.in_valid = 0; bus16.in_x = '0; bus16.in_w = '0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_calc_1[%0d]", i), c1_16, exp_c1[i]);
            check($sformatf("t1_calc_in[%0d]", i), cin_16, exp_cin[i]);
            check($sformatf("t1_clr[%0d]", i), clr_16, 0);
            check($sformatf("t1_in_ready[%0d]", i), bus16.in_ready, 0);
            tick();
        end
        check("t1_sample_clr", clr_16, 0);
        check("t1_sample_busy", busy_16, 1);
        check("t1_sample_calc_1", c1_16, 0);
        check("t1_sample_out_valid", bus16.out_valid, 0);
        act_16 = 1; sum_16 = 12'sd5;
        tick();
        act_16 = 0; sum_16 = '0;
        check("t1_out_valid", bus16.out_valid, 1);
        check("t1_res_act", bus16.res_act, 1);
        check("t1_done_clr", clr_16, 1);
        check("t1_done_busy", busy_16, 0);
`ifdef CALC_DRV_SUM_EN
        check("t1_res_sum", $unsigned(bus16.res_sum), 12'd5);
`endif

        // Backpressure in DONE with a new vector already offered
        bus16.in_valid = 1; bus16.in_x = 16'h0001; bus16.in_w = 16'h8000;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_out_valid[%0d]", i), bus16.out_valid, 1);
            check($sformatf("bp_in_ready[%0d]", i), bus16.in_ready, 0);
            check($sformatf("bp_res_act[%0d]", i), bus16.res_act, 1);
            check($sformatf("bp_busy[%0d]", i), busy_16, 0);
`ifdef CALC_DRV_SUM_EN
            check($sformatf("bp_res_sum[%0d]", i), $unsigned(bus16.res_sum), 12'd5);
`endif
            tick();
        end
        bus16.out_ready = 1;
        tick();
        check("bp_idle_in_ready", bus16.in_ready, 1);
        check("bp_idle_out_valid", bus16.out_valid, 0);
        check("bp_idle_busy", busy_16, 0);
        bus16.out_ready = 0;
        tick();
        bus16.in_valid = 0; bus16.in_x = '0; bus16.in_w = '0;

        // T2: vector 0001/8000, negative sum
        check("t2_calc_1[0]", c1_16, 1);
        check("t2_calc_in[0]", cin_16, 0);
        check("t2_busy", busy_16, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("t2_calc_1[%0d]", i), c1_16, 0);
            check($sformatf("t2_calc_in[%0d]", i), cin_16, (i == 15) ? 1 : 0);
        end
        tick();
        check("t2_sample_busy", busy_16, 1);
        act_16 = 0; sum_16 = 12'hFF6;
        tick();
        sum_16 = '0;
        check("t2_out_valid", bus16.out_valid, 1);
        check("t2_res_act", bus16.res_act, 0);
`ifdef CALC_DRV_SUM_EN
        check("t2_res_sum", $unsigned(bus16.res_sum), 12'hFF6);
`endif
        bus16.out_ready = 1;
        tick();
        check("t2_idle_in_ready", bus16.in_ready, 1);

        // T3: out_ready held high in advance, result stays after handshake
        bus16.in_x = 16'hFFFF; bus16.in_w = 16'hFFFF; bus16.in_valid = 1;
        tick();
        bus16.in_valid = 0;
        repeat (16) tick();
        act_16 = 1; sum_16 = 12'sd7;
        tick();
        act_16 = 0; sum_16 = '0;
        check("t3_out_valid", bus16.out_valid, 1);
        check("t3_res_act", bus16.res_act, 1);
        tick();
        check("t3_idle_out_valid", bus16.out_valid, 0);
        check("t3_idle_res_act", bus16.res_act, 1);
`ifdef CALC_DRV_SUM_EN
        check("t3_idle_res_sum", $unsigned(bus16.res_sum), 12'd7);
`endif
        bus16.out_ready = 0;

        // T4: asynchronous reset at bit 5
        bus16.in_valid = 1;
        tick();
        bus16.in_valid = 0;
        repeat (5) tick();
        check("t4_bit5_calc_1", c1_16, 1);
        check("t4_bit5_calc_in", cin_16, 1);
        #2 rst = 0;
        #1;
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_calc_clr", clr_16, 1);
        check("rst_calc_1", c1_16, 0);
        check("rst_calc_in", cin_16, 0);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_busy", busy_16, 0);
        check("rst_res_act", bus16.res_act, 0);
`ifdef CALC_DRV_SUM_EN
        check("rst_res_sum", $unsigned(bus16.res_sum), 0);
`endif
        @(negedge clk) rst = 1;
        tick();
        check("post_rst_in_ready", bus16.in_ready, 1);
        check("post_rst_calc_clr", clr_16, 1);
        check("post_rst_busy", busy_16, 0);

        // VEC_LEN=1 instance
        bus1.in_x = 1'b1; bus1.in_w = 1'b0; bus1.in_valid = 1;
        tick();
        bus1.in_valid = 0; bus1.in_x = '0;
        check("v1_calc_1", c1_1, 1);
        check("v1_calc_in", cin_1, 0);
        check("v1_clr", clr_1, 0);
        tick();
        check("v1_sample_calc_1", c1_1, 0);
        check("v1_sample_busy", busy_1, 1);
        check("v1_sample_out_valid", bus1.out_valid, 0);
        act_1 = 1;
        tick();
        act_1 = 0;
        check("v1_out_valid", bus1.out_valid, 1);
        check("v1_res_act", bus1.res_act, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
